// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue between fetch and decode, with flush on redirect.
// Empty head presents a NOP so decode never sees stale data.
module fetch_queue #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_flush,
   input  logic             i_enq_valid,
   input  logic [31:0]      i_enq_pc,
   input  logic [31:0]      i_enq_inst,
   output logic             o_enq_ready,
   output logic             o_deq_valid,
   input  logic             i_deq_ready,
   output logic [31:0]      o_deq_pc,
   output logic [31:0]      o_deq_inst,
   output logic [PTR_W:0]   o_count,
   output logic             o_full,
   output logic             o_empty
);
   logic [31:0]      r_pc   [DEPTH];
   logic [31:0]      r_inst [DEPTH];
   logic [PTR_W-1:0] r_wp, r_rp;
   logic [PTR_W:0]   r_cnt;
   logic             w_enq, w_deq;

   assign o_full      = r_cnt == (PTR_W+1)'(DEPTH);
   assign o_empty     = r_cnt == '0;
   assign o_count     = r_cnt;
   assign o_enq_ready = !o_full;
   assign o_deq_valid = !o_empty;
   assign o_deq_pc    = o_empty ? 32'h0 : r_pc[r_rp];
   assign o_deq_inst  = o_empty ? 32'h0000_0013 : r_inst[r_rp];
   assign w_enq       = i_enq_valid && o_enq_ready && !i_flush;
   assign w_deq       = o_deq_valid && i_deq_ready && !i_flush;

   // Storage is left uncleared on reset/flush; occupancy alone decides validity.
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_pc[r_wp]   <= i_enq_pc;
         r_inst[r_wp] <= i_enq_inst;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (i_flush) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_enq) r_wp <= r_wp + 1'b1;
         if (w_deq) r_rp <= r_rp + 1'b1;
         if (w_enq && !w_deq) r_cnt <= r_cnt + 1'b1;
         else if (w_deq && !w_enq) r_cnt <= r_cnt - 1'b1;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of ordering, full/empty limits, wrap, flush and async reset.
module tb_fetch_queue;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        enq_valid = 1'b0;
   logic [31:0] enq_pc = '0;
   logic [31:0] enq_inst = '0;
   logic        enq_ready, deq_valid, full, empty;
   logic        deq_ready = 1'b0;
   logic [31:0] deq_pc, deq_inst;
   logic [3:0]  count;
   int          n_chk = 0;
   int          n_err = 0;

   fetch_queue #(.DEPTH(8), .PTR_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .i_flush(flush),
      .i_enq_valid(enq_valid), .i_enq_pc(enq_pc), .i_enq_inst(enq_inst),
      .o_enq_ready(enq_ready), .o_deq_valid(deq_valid), .i_deq_ready(deq_ready),
      .o_deq_pc(deq_pc), .o_deq_inst(deq_inst), .o_count(count),
      .o_full(full), .o_empty(empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'hA5A5_0000;
   endfunction

   task automatic put(input logic [31:0] pc);
      enq_pc   = pc;
      enq_inst = inst_of(pc);
   endtask

   task automatic chk_empty(input string tag);
      chk({tag, "_empty"}, 32'(empty), 32'd1);
      chk({tag, "_dvalid"}, 32'(deq_valid), 32'd0);
      chk({tag, "_count"}, 32'(count), 32'd0);
      chk({tag, "_pc"}, deq_pc, 32'h0);
      chk({tag, "_inst"}, deq_inst, 32'h0000_0013);
   endtask

   initial begin
      #2;
      chk_empty("rst");
      chk("rst_erdy", 32'(enq_ready), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();
      // basic ordering with decode stalled, then drain
      enq_valid = 1'b1;
      put(32'h0);
      cyc();
      chk("lat_dvalid", 32'(deq_valid), 32'd1);
      put(32'h4);
      cyc();
      put(32'h8);
      cyc();
      enq_valid = 1'b0;
      chk("b_count", 32'(count), 32'd3);
      chk("b_pc0", deq_pc, 32'h0);
      deq_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("b_drain_pc", deq_pc, 32'(4 * i));
         chk("b_drain_inst", deq_inst, inst_of(32'(4 * i)));
         cyc();
      end
      chk_empty("b_end");
      deq_ready = 1'b0;
      // fill to full, then one dequeue while enqueue is blocked
      enq_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         put(32'h200 + 32'(4 * i));
         cyc();
      end
      chk("f_full", 32'(full), 32'd1);
      chk("f_erdy", 32'(enq_ready), 32'd0);
      chk("f_count", 32'(count), 32'd8);
      put(32'h999);
      deq_ready = 1'b1;
      cyc();
      enq_valid = 1'b0;
      chk("f_count7", 32'(count), 32'd7);
      chk("f_notfull", 32'(full), 32'd0);
      for (int i = 1; i < 8; i++) begin
         chk("f_drain_pc", deq_pc, 32'h200 + 32'(4 * i));
         cyc();
      end
      chk_empty("f_end");
      // continuous streaming across pointer wrap
      enq_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         put(32'h300 + 32'(4 * i));
         cyc();
         chk("s_count", 32'(count), 32'd1);
         chk("s_pc", deq_pc, 32'h300 + 32'(4 * i));
      end
      enq_valid = 1'b0;
      cyc();
      chk_empty("s_end");
      deq_ready = 1'b0;
      // flush with concurrent enqueue/dequeue requests
      enq_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         put(32'h400 + 32'(4 * i));
         cyc();
      end
      chk("fl_count5", 32'(count), 32'd5);
      flush = 1'b1;
      deq_ready = 1'b1;
      put(32'h500);
      #1;
      chk("fl_hold_count", 32'(count), 32'd5);
      chk("fl_hold_pc", deq_pc, 32'h400);
      cyc();
      flush = 1'b0;
      enq_valid = 1'b0;
      deq_ready = 1'b0;
      chk_empty("fl_after");
      chk("fl_erdy", 32'(enq_ready), 32'd1);
      cyc();
      chk_empty("fl_drop");
      // async reset between edges with entries queued
      enq_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         put(32'h600 + 32'(4 * i));
         cyc();
      end
      enq_valid = 1'b0;
      chk("ar_count3", 32'(count), 32'd3);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_empty("ar_async");
      #1;
      rst_n = 1'b1;
      enq_valid = 1'b1;
      put(32'h100);
      cyc();
      enq_valid = 1'b0;
      chk("ar_pc", deq_pc, 32'h100);
      chk("ar_count", 32'(count), 32'd1);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
